// File: rtl/fp2fix_conv_if.sv
// fp2fix_conv_if: input/output valid-ready bundle for the float-to-fixed converter
interface fp2fix_conv_if #(
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      data_in;
    logic [4:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] data_out;
    logic [4:0]       flags;
    modport master (
        output in_valid, data_in, control, out_ready,
        input  in_ready, out_valid, data_out, flags
    );
    modport slave (
        input  in_valid, data_in, control, out_ready,
        output in_ready, out_valid, data_out, flags
    );
endinterface

// File: rtl/fp2fix_conv.sv
// fp2fix_conv: 3-stage IEEE-754 single to signed OUT_W-bit fixed point converter
module fp2fix_conv #(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 0
) (
    input logic          clk,
    input logic          reset,
    fp2fix_conv_if.slave bus
);
    localparam int MW = OUT_W + 24;
    localparam logic signed [9:0] KFRAC = 10'(FRAC_W);
    localparam logic signed [9:0] KOVF  = 10'(OUT_W);
    localparam logic signed [9:0] K23   = 10'sd23;
    localparam logic signed [9:0] KFAR  = -10'sd3;
    localparam logic [OUT_W+1:0] POS_LIM = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W+1:0] NEG_LIM = {3'b001, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
    logic adv;
    logic v1, sign1, nan1, inf1;
    logic [1:0] rm1;
    logic [23:0] sig1;
    logic signed [9:0] k1;
    logic v2, sign2, nan2, ovf2, g2, s2;
    logic [1:0] rm2;
    logic [OUT_W-1:0] mag2;
    logic out_valid;
    logic [OUT_W-1:0] data_out;
    logic [4:0] flags;
    logic [7:0] e_in;
    logic signed [9:0] k_c;
    logic big, left, far, g_c, s_c;
    logic [9:0] lsh, rsh;
    logic [49:0] wide;
    logic [OUT_W-1:0] mag_c;
    logic inc, sat;
    logic [OUT_W+1:0] rnd, neg;
    logic [OUT_W-1:0] dout_c;
    logic [4:0] flags_c;

    assign adv           = !out_valid || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid;
    assign bus.data_out  = data_out;
    assign bus.flags     = flags;

    // k is the bit position of the integer LSB relative to the significand's leading one
    assign e_in = bus.data_in[30:23];
    assign k_c  = (e_in == 8'd0 ? -10'sd126 : $signed({2'b00, e_in}) - 10'sd127) + KFRAC;

    // Right shifts of 26 or more leave nothing in mag or guard; only sticky survives
    always_comb begin
        big    = nan1 || inf1 || k1 >= KOVF;
        left   = k1 >= K23;
        far    = k1 <= KFAR;
        lsh    = k1 - K23;
        rsh    = K23 - k1;
        wide   = {sig1, 26'b0} >> rsh;
        mag_c  = (big || far) ? '0 : left ? OUT_W'(MW'(sig1) << lsh) : OUT_W'(wide[49:26]);
        g_c    = !big && !left && !far && wide[25];
        s_c    = !big && !left && (far ? |sig1 : |wide[24:0]);
    end

    // Rounding runs in OUT_W+2 bits so the carry out of the magnitude is kept for saturation
    always_comb begin
        inc     = rm2 == 2'd0 ? g2 && (s2 || mag2[0]) :
                  rm2 == 2'd1 ? 1'b0 :
                  rm2 == 2'd2 ? !sign2 && (g2 || s2) : sign2 && (g2 || s2);
        rnd     = {2'b00, mag2} + {{(OUT_W+1){1'b0}}, inc};
        neg     = -rnd;
        sat     = ovf2 || rnd > (sign2 ? NEG_LIM : POS_LIM);
        dout_c  = nan2 ? '0 : sat ? (sign2 ? MIN_V : MAX_V) : sign2 ? neg[OUT_W-1:0] : rnd[OUT_W-1:0];
        flags_c = {nan2, !nan2 && sat, dout_c == '0, 1'b0, !nan2 && (g2 || s2)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            flags     <= '0;
        end else if (adv) begin
            v1        <= bus.in_valid;
            sign1     <= bus.data_in[31];
            nan1      <= &e_in && |bus.data_in[22:0];
            inf1      <= &e_in && !(|bus.data_in[22:0]);
            sig1      <= {|e_in, bus.data_in[22:0]};
            k1        <= k_c;
            rm1       <= bus.control[1:0];
            v2        <= v1;
            sign2     <= sign1;
            nan2      <= nan1;
            ovf2      <= big && !nan1;
            mag2      <= mag_c;
            g2        <= g_c;
            s2        <= s_c;
            rm2       <= rm1;
            out_valid <= v2;
            data_out  <= dout_c;
            flags     <= flags_c;
        end
    end
endmodule

// File: tb/tb_fp2fix_conv.sv
// tb_fp2fix_conv: table vectors, stall/reset sequences and a randomized real-arithmetic reference model
module tb_fp2fix_conv;
    localparam int OUT_W  = 16;
    localparam int FRAC_W = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp2fix_conv_if #(.OUT_W(OUT_W)) bus ();
    fp2fix_conv #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0]      d;
        logic [1:0]       rm;
        logic [OUT_W-1:0] q;
        logic [4:0]       f;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact value |x|*2^FRAC_W in reals, then the rounding rules applied arithmetically
    function automatic void model(input logic [31:0] d, input logic [1:0] rm,
                                  output logic [OUT_W-1:0] q, output logic [4:0] f);
        int ex, sigv;
        real a, fl, fr;
        longint mag, v, lim;
        logic s, sat, inx;
        s   = d[31];
        ex  = int'(d[30:23]);
        lim = longint'(1) <<< (OUT_W - 1);
        if (ex == 255 && d[22:0] != 0) begin
            q = '0;
            f = 5'b10100;
            return;
        end
        if (ex == 255) begin
            q = s ? OUT_W'(-lim) : OUT_W'(lim - 1);
            f = 5'b01000;
            return;
        end
        sigv = int'({ex != 0, d[22:0]});
        a = real'(sigv) * (2.0 ** ((ex == 0 ? -126 : ex - 127) - 23 + FRAC_W));
        v = 0;
        if (a >= 2.0 ** OUT_W) begin
            sat = 1'b1;
            inx = 1'b0;
        end else begin
            fl  = $floor(a);
            fr  = a - fl;
            mag = longint'($rtoi(fl));
            if (rm == 2'd0 && (fr > 0.5 || (fr == 0.5 && mag[0]))) mag++;
            if (rm == 2'd2 && !s && fr > 0.0) mag++;
            if (rm == 2'd3 && s && fr > 0.0) mag++;
            v   = s ? -mag : mag;
            sat = v > lim - 1 || v < -lim;
            inx = fr != 0.0;
        end
        q = sat ? (s ? OUT_W'(-lim) : OUT_W'(lim - 1)) : OUT_W'(v);
        f = {1'b0, sat, q == '0, 1'b0, inx};
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] d;
        d = $urandom;
        if ($urandom_range(7) != 0) d[30:23] = 8'($urandom_range(150, 100));
        return d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic convert(input logic [31:0] d, input logic [1:0] rm,
                           output logic [OUT_W-1:0] q, output logic [4:0] f, output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.data_in   = d;
        bus.control   = {3'($urandom), rm};
        bus.out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        q = bus.data_out;
        f = bus.flags;
    endtask

    // mode 0: back-to-back input with a 4-cycle out_ready stall; mode 1: random gaps and backpressure
    task automatic stream(input int n, input int mode);
        logic [OUT_W-1:0] eq[$];
        logic [4:0] fq[$];
        logic [OUT_W-1:0] hd, q;
        logic [4:0] hf, f;
        logic [31:0] d;
        logic [1:0] rm;
        logic hold;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; hold = 1'b0;
        hd = '0; hf = '0;
        d = gen();
        rm = 2'($urandom);
        while (got < n && cyc < 4000) begin
            @(negedge clk);
            bus.out_ready = mode == 0 ? !(cyc >= 5 && cyc < 9) : $urandom_range(3) != 0;
            bus.in_valid  = sent < n && (mode == 0 || $urandom_range(4) != 0);
            bus.data_in   = d;
            bus.control   = {3'($urandom), rm};
            #1;
            if (hold) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.data_out), 32'(hd));
                check("hold_flags", 32'(bus.flags), 32'(hf));
            end
            if (bus.out_valid && !bus.out_ready) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (eq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_output: got %h expected none", bus.data_out);
                end else begin
                    check("stream_data", 32'(bus.data_out), 32'(eq.pop_front()));
                    check("stream_flags", 32'(bus.flags), 32'(fq.pop_front()));
                    got++;
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            hd = bus.data_out;
            hf = bus.flags;
            if (bus.in_valid && bus.in_ready) begin
                model(d, rm, q, f);
                eq.push_back(q);
                fq.push_back(f);
                sent++;
                d = gen();
                rm = 2'($urandom);
            end
            @(posedge clk);
            cyc++;
        end
        if (got < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout: got %0d outputs expected %0d", got, n);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_extra", 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        vec_t tbl[$];
        logic [OUT_W-1:0] q;
        logic [4:0] f;
        int lat;
        tbl = '{
            '{32'h3FC00000, 2'd0, 16'h0002, 5'b00001},
            '{32'h3FC00000, 2'd1, 16'h0001, 5'b00001},
            '{32'h3FC00000, 2'd2, 16'h0002, 5'b00001},
            '{32'hC0200000, 2'd0, 16'hFFFE, 5'b00001},
            '{32'hC0200000, 2'd3, 16'hFFFD, 5'b00001},
            '{32'hC0200000, 2'd2, 16'hFFFE, 5'b00001},
            '{32'hC0200000, 2'd1, 16'hFFFE, 5'b00001},
            '{32'h46FFFF00, 2'd0, 16'h7FFF, 5'b01001},
            '{32'h46FFFF00, 2'd1, 16'h7FFF, 5'b00001},
            '{32'hC7000000, 2'd0, 16'h8000, 5'b00000},
            '{32'h7FC00000, 2'd0, 16'h0000, 5'b10100},
            '{32'hFF800000, 2'd0, 16'h8000, 5'b01000},
            '{32'h7F800000, 2'd1, 16'h7FFF, 5'b01000},
            '{32'h00000001, 2'd0, 16'h0000, 5'b00101},
            '{32'h00000001, 2'd2, 16'h0001, 5'b00001},
            '{32'h80000000, 2'd0, 16'h0000, 5'b00100},
            '{32'h3F000000, 2'd0, 16'h0000, 5'b00101},
            '{32'h40200000, 2'd0, 16'h0002, 5'b00001},
            '{32'h47000000, 2'd1, 16'h7FFF, 5'b01000},
            '{32'hC7000080, 2'd0, 16'h8000, 5'b00001},
            '{32'hC7000080, 2'd3, 16'h8000, 5'b01001},
            '{32'h42F60000, 2'd0, 16'h007B, 5'b00000},
            '{32'hC2F60000, 2'd1, 16'hFF85, 5'b00000}
        };
        bus.in_valid = 1'b0;
        bus.data_in = '0;
        bus.control = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_data_out", 32'(bus.data_out), 32'd0);
        check("reset_flags", 32'(bus.flags), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);

        foreach (tbl[i]) begin
            convert(tbl[i].d, tbl[i].rm, q, f, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_data", i), 32'(q), 32'(tbl[i].q));
            check($sformatf("vec%0d_flags", i), 32'(f), 32'(tbl[i].f));
        end

        stream(8, 0);

        // Two items in flight when reset hits must vanish without a trace
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.data_in = 32'h42F60000;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.data_in = 32'h3FC00000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midreset_no_stale", 32'(bus.out_valid), 32'd0);
        end

        do_reset();
        stream(400, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
